// File: rtl/pad_cfg_sequencer_if.sv
// Pad configuration write port: one pad update per valid/ready transfer,
// plus done/error pulses back to the requester.
interface pad_cfg_sequencer_if #(
  parameter int NUM_BIDIR_PADS = 40
);
  localparam int AW = $clog2(NUM_BIDIR_PADS);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [5:0]    cfg_data;
  logic          cfg_done;
  logic          cfg_err;

  modport master (
    output cfg_valid, cfg_addr, cfg_data,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data,
    output cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/pad_cfg_sequencer.sv
// Drives OE/CS/SL/IE/PU/PD of every bidir pad, applying each update glitch-safely
// (OE off, turnaround, static controls, settle, OE on). PAD_CFG_READBACK_EN adds a read port.
module pad_cfg_sequencer #(
  parameter  int NUM_BIDIR_PADS = 40,
  parameter  int TURN_CYCLES    = 4,
  localparam int AW             = $clog2(NUM_BIDIR_PADS)
) (
  input  logic                      clk,
  input  logic                      rst,
  pad_cfg_sequencer_if.slave        cfg,
  output logic                      busy,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd
`ifdef PAD_CFG_READBACK_EN
  ,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  output logic [5:0]                rd_data
`endif
);

  localparam int            CW        = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
  localparam logic [AW:0]   NUM_LIMIT = (AW+1)'(NUM_BIDIR_PADS);

  typedef enum logic [2:0] {IDLE, OE_OFF, TURN, APPLY, SETTLE, OE_ON, DONE} state_t;

  state_t        state;
  logic [AW-1:0] lat_addr;
  logic [5:0]    lat_data;
  logic [CW-1:0] wait_cnt;
  logic          done_q;
  logic          err_q;
  logic          req_bad;
  logic          need_oe_off;
  logic [4:0]    cur_static;

  assign cfg.cfg_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;

  // OE must drop first only if it is on and the update would change anything under it.
  always_comb begin
    req_bad     = ({1'b0, cfg.cfg_addr} >= NUM_LIMIT) || (cfg.cfg_data[4] && cfg.cfg_data[5]);
    cur_static  = {bidir_pd[cfg.cfg_addr], bidir_pu[cfg.cfg_addr], bidir_ie[cfg.cfg_addr],
                   bidir_sl[cfg.cfg_addr], bidir_cs[cfg.cfg_addr]};
    need_oe_off = bidir_oe[cfg.cfg_addr] && (!cfg.cfg_data[0] || (cur_static != cfg.cfg_data[5:1]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      wait_cnt <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      bidir_oe <= '0;
      bidir_cs <= '0;
      bidir_sl <= '0;
      bidir_ie <= '1;
      bidir_pu <= '0;
      bidir_pd <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_valid) begin
            if (req_bad) begin
              err_q <= 1'b1;
            end else begin
              lat_addr <= cfg.cfg_addr;
              lat_data <= cfg.cfg_data;
              state    <= need_oe_off ? OE_OFF : APPLY;
            end
          end
        end
        OE_OFF: begin
          bidir_oe[lat_addr] <= 1'b0;
          if (TURN_CYCLES == 0) begin
            state <= APPLY;
          end else begin
            wait_cnt <= CW'(TURN_CYCLES - 1);
            state    <= TURN;
          end
        end
        TURN: begin
          if (wait_cnt == '0) state <= APPLY;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        APPLY: begin
          bidir_cs[lat_addr] <= lat_data[1];
          bidir_sl[lat_addr] <= lat_data[2];
          bidir_ie[lat_addr] <= lat_data[3];
          bidir_pu[lat_addr] <= lat_data[4];
          bidir_pd[lat_addr] <= lat_data[5];
          if (lat_data[0] && !bidir_oe[lat_addr]) begin
            if (TURN_CYCLES == 0) begin
              state <= OE_ON;
            end else begin
              wait_cnt <= CW'(TURN_CYCLES - 1);
              state    <= SETTLE;
            end
          end else begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        SETTLE: begin
          if (wait_cnt == '0) state <= OE_ON;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        OE_ON: begin
          bidir_oe[lat_addr] <= 1'b1;
          done_q             <= 1'b1;
          state              <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PAD_CFG_READBACK_EN
  // Reads see the live pad registers, so mid-sequence values are visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if ({1'b0, rd_addr} >= NUM_LIMIT) rd_data <= '0;
      else rd_data <= {bidir_pd[rd_addr], bidir_pu[rd_addr], bidir_ie[rd_addr],
                       bidir_sl[rd_addr], bidir_cs[rd_addr], bidir_oe[rd_addr]};
    end
  end
`endif

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Self-checking bench for pad_cfg_sequencer: directed plan steps, then random updates
// compared cycle by cycle against a timeline model derived from the update rules.
module tb_pad_cfg_sequencer;
  localparam int NUM = 40;
  localparam int TC  = 4;
  localparam int AW  = $clog2(NUM);

  logic           clk = 1'b0;
  logic           rst;
  logic           busy;
  logic [NUM-1:0] bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
`ifdef PAD_CFG_READBACK_EN
  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [5:0]     rd_data;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [5:0] mdl [NUM];

  pad_cfg_sequencer_if #(.NUM_BIDIR_PADS(NUM)) cfg_bus ();

  pad_cfg_sequencer #(.NUM_BIDIR_PADS(NUM), .TURN_CYCLES(TC)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg      (cfg_bus),
    .busy     (busy),
    .bidir_oe (bidir_oe),
    .bidir_cs (bidir_cs),
    .bidir_sl (bidir_sl),
    .bidir_ie (bidir_ie),
    .bidir_pu (bidir_pu),
    .bidir_pd (bidir_pd)
`ifdef PAD_CFG_READBACK_EN
    ,
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [6*NUM-1:0] padsActual();
    return {bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd};
  endfunction

  // Model bank with pad 'a' replaced by 'v' (a < 0: no override).
  function automatic logic [6*NUM-1:0] padsExpected(input int a, input logic [5:0] v);
    logic [NUM-1:0] o, c, s, i, u, d;
    logic [5:0]     x;
    for (int p = 0; p < NUM; p++) begin
      x    = (p == a) ? v : mdl[p];
      o[p] = x[0]; c[p] = x[1]; s[p] = x[2];
      i[p] = x[3]; u[p] = x[4]; d[p] = x[5];
    end
    return {o, c, s, i, u, d};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int p = 0; p < NUM; p++) mdl[p] = 6'b001000;
  endtask

  // Issues one request in an idle cycle and checks every cycle until the sequencer is idle again.
  // abortAt > 0 pulses rst in that cycle; holdValid keeps the request asserted with nextD.
  task automatic applyStimulus(input int a, input logic [5:0] d, input int abortAt,
                               input bit holdValid, input logic [5:0] nextD);
    logic [5:0] old, cur;
    bit         bad, needOff, needOn;
    int         offC, onC, doneRel;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = AW'(a);
    cfg_bus.cfg_data  = d;
    bad = (a >= NUM) || (d[4] && d[5]);
    if (bad) begin
      @(posedge clk); #1;
      cfg_bus.cfg_valid = 1'b0;
      checkOutput("err_pulse", 256'(cfg_bus.cfg_err), 256'(1'b1));
      checkOutput("err_ready", 256'(cfg_bus.cfg_ready), 256'(1'b1));
      checkOutput("err_pads", 256'(padsActual()), 256'(padsExpected(-1, 6'b0)));
      @(posedge clk); #1;
      checkOutput("err_clear", 256'(cfg_bus.cfg_err), 256'(1'b0));
      checkOutput("err_nodone", 256'(cfg_bus.cfg_done), 256'(1'b0));
      return;
    end
    old     = mdl[a];
    needOff = old[0] && (!d[0] || (old[5:1] != d[5:1]));
    needOn  = d[0] && (!old[0] || needOff);
    offC    = needOff ? TC + 1 : 0;
    onC     = needOn  ? TC + 1 : 0;
    doneRel = 2 + offC + onC;
    for (int n = 1; n <= doneRel + 1; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        if (holdValid) cfg_bus.cfg_data = nextD;
        else           cfg_bus.cfg_valid = 1'b0;
      end
      cur = old;
      if (n >= 2 + offC)          cur[5:1] = d[5:1];
      if (needOff && n >= 2)      cur[0]   = 1'b0;
      if (needOn && n >= doneRel) cur[0]   = 1'b1;
      checkOutput("pads", 256'(padsActual()), 256'(padsExpected(a, cur)));
      checkOutput("done", 256'(cfg_bus.cfg_done), 256'(n == doneRel));
      checkOutput("ready", 256'(cfg_bus.cfg_ready), 256'(n > doneRel));
      checkOutput("busy", 256'(busy), 256'(n <= doneRel));
      checkOutput("err", 256'(cfg_bus.cfg_err), 256'(1'b0));
      if (n == abortAt) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        resetModel();
        checkOutput("rst_pads", 256'(padsActual()), 256'(padsExpected(-1, 6'b0)));
        checkOutput("rst_ready", 256'(cfg_bus.cfg_ready), 256'(1'b1));
        checkOutput("rst_done", 256'(cfg_bus.cfg_done), 256'(1'b0));
        repeat (TC + 8) begin
          @(posedge clk); #1;
          checkOutput("rst_nodone", 256'(cfg_bus.cfg_done), 256'(1'b0));
        end
        checkOutput("rst_hold", 256'(padsActual()), 256'(padsExpected(-1, 6'b0)));
        return;
      end
    end
    mdl[a] = d;
  endtask

`ifdef PAD_CFG_READBACK_EN
  task automatic checkReadback(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    @(posedge clk); #1;
    rd_en = 1'b0;
    checkOutput("readback", 256'(rd_data), 256'((a < NUM) ? mdl[a] : 6'b0));
  endtask
`endif

  initial begin
    int         a;
    logic [5:0] d;
    rst               = 1'b1;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_addr  = '0;
    cfg_bus.cfg_data  = '0;
`ifdef PAD_CFG_READBACK_EN
    rd_en   = 1'b0;
    rd_addr = '0;
`endif
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_pads", 256'(padsActual()), 256'(padsExpected(-1, 6'b0)));
    checkOutput("rst_ready", 256'(cfg_bus.cfg_ready), 256'(1'b1));
    checkOutput("rst_busy", 256'(busy), 256'(1'b0));
    checkOutput("rst_done", 256'(cfg_bus.cfg_done), 256'(1'b0));
    checkOutput("rst_err", 256'(cfg_bus.cfg_err), 256'(1'b0));
`ifdef PAD_CFG_READBACK_EN
    checkOutput("rst_rd", 256'(rd_data), 256'(6'b0));
`endif

    $display("[TB] directed plan steps");
    applyStimulus(3, 6'b001000, 0, 1'b0, 6'b0);
    applyStimulus(5, 6'b000001, 0, 1'b0, 6'b0);
    applyStimulus(5, 6'b001000, 0, 1'b0, 6'b0);
    applyStimulus(5, 6'b000001, 0, 1'b0, 6'b0);
    applyStimulus(5, 6'b000111, 0, 1'b0, 6'b0);
    applyStimulus(NUM, 6'b000001, 0, 1'b0, 6'b0);
    applyStimulus(7, 6'b110000, 0, 1'b0, 6'b0);
`ifdef PAD_CFG_READBACK_EN
    checkReadback(5);
    checkReadback(NUM + 2);
`endif

    $display("[TB] reset during turnaround");
    applyStimulus(5, 6'b001000, 3, 1'b0, 6'b0);

    $display("[TB] backpressure");
    applyStimulus(9, 6'b000010, 0, 1'b1, 6'b000001);
    applyStimulus(9, 6'b000001, 0, 1'b0, 6'b0);

    $display("[TB] random updates");
    for (int k = 0; k < 40; k++) begin
      a = $urandom_range(0, NUM + 3);
      d = 6'($urandom);
      if (k % 4 == 0 && a < NUM) d[5:1] = mdl[a][5:1];
      applyStimulus(a, d, 0, 1'b0, 6'b0);
`ifdef PAD_CFG_READBACK_EN
      checkReadback($urandom_range(0, NUM + 3));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
